// File: rtl/mpeg2_pkg.sv
// Shared types and helpers for the MPEG-2 pixel front-end.
package mpeg2_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StActive  = 2'd1,
      StStopped = 2'd2
   } state_e;

   localparam logic CHROMA_444 = 1'b0;
   localparam logic CHROMA_DUP = 1'b1;

   // Four output beats of 4 pixels cover one 16-pixel macroblock row segment
   function automatic int unsigned beats_per_row(input int unsigned xsize16);
      return 4 * xsize16;
   endfunction

   // Even-sample chroma duplication: lane 1 takes lane 0, lane 3 takes lane 2
   function automatic logic [31:0] dup_even(input logic [31:0] c);
      return {c[23:16], c[23:16], c[7:0], c[7:0]};
   endfunction

endpackage

// File: rtl/mpeg2_pix_acc.sv
// Lane accumulator: gathers 4/IN_PIX input beats into one 4-pixel group.
// done is combinational and coincides with the beat that completes the group;
// grp_* carries the stored lanes merged with the current input beat.
module mpeg2_pix_acc #(
   parameter int unsigned IN_PIX = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                clr,
   input  logic                en,
   input  logic [8*IN_PIX-1:0] y,
   input  logic [8*IN_PIX-1:0] u,
   input  logic [8*IN_PIX-1:0] v,
   output logic                done,
   output logic [31:0]         grp_y,
   output logic [31:0]         grp_u,
   output logic [31:0]         grp_v
);

   localparam int unsigned W     = 8 * IN_PIX;
   localparam int unsigned NLANE = 4 / IN_PIX;

   logic [1:0]  lane_q;
   logic [31:0] y_q, u_q, v_q;
   int unsigned base;

   // Merge the incoming beat into its lane slot and flag the last lane
   always_comb begin
      base  = W * 32'(lane_q);
      grp_y = y_q;
      grp_u = u_q;
      grp_v = v_q;
      grp_y[base +: W] = y;
      grp_u[base +: W] = u;
      grp_v[base +: W] = v;
      done  = en && (32'(lane_q) == NLANE - 1);
   end

   // Lane pointer and partial-group storage
   always_ff @(posedge clk) begin
      if (!rstn) begin
         lane_q <= '0;
         y_q    <= '0;
         u_q    <= '0;
         v_q    <= '0;
      end else if (clr) begin
         lane_q <= '0;
      end else if (en) begin
         y_q    <= grp_y;
         u_q    <= grp_u;
         v_q    <= grp_v;
         lane_q <= done ? 2'd0 : lane_q + 2'd1;
      end
   end

endmodule

// File: rtl/mpeg2_pixel_packer.sv
// Pixel front-end for mpeg2encoder: packs 1/2/4-pixel beats into 4-pixel
// beats, applies chroma mode, tracks frame geometry and defers sequence stop
// to a frame boundary. Define MPEG2_PACKER_STATS_EN to add frame/drop counters.
module mpeg2_pixel_packer
   import mpeg2_pkg::*;
#(
   parameter int unsigned IN_PIX = 4,
   parameter int unsigned XL     = 6,
   parameter int unsigned YL     = 6
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [XL:0]         i_xsize16,
   input  logic [YL:0]         i_ysize16,
   input  logic                i_chroma_mode,
   input  logic                i_en,
   input  logic [8*IN_PIX-1:0] i_Y,
   input  logic [8*IN_PIX-1:0] i_U,
   input  logic [8*IN_PIX-1:0] i_V,
   input  logic                i_stop_req,
   input  logic                i_sequence_busy,
   output logic                o_en,
   output logic [31:0]         o_Y,
   output logic [31:0]         o_U,
   output logic [31:0]         o_V,
   output logic                o_frame_start,
   output logic                o_frame_end,
   output logic                o_sequence_stop,
`ifdef MPEG2_PACKER_STATS_EN
   output logic [15:0]         o_frame_count,
   output logic [15:0]         o_drop_count,
`endif
   output logic                o_cfg_err
);

   state_e        state_q;
   logic          stop_flag_q;
   logic [XL:0]   xsize_q, xsize_cur;
   logic [YL:0]   ysize_q, ysize_cur;
   logic [XL+1:0] bx_q;
   logic [YL+3:0] row_q;
   logic          size_zero_in, accept, acc_clr, grp_done;
   logic          last_col, last_row, last_beat, first_beat;
   logic [31:0]   grp_y, grp_u, grp_v;

   // Acceptance and geometry decode; in IDLE the live sizes are about to be latched
   always_comb begin
      size_zero_in = (i_xsize16 == '0) || (i_ysize16 == '0);
      accept       = i_en && ((state_q == StIdle && !stop_flag_q && !size_zero_in) ||
                              state_q == StActive);
      acc_clr      = (state_q == StStopped);
      xsize_cur    = (state_q == StIdle) ? i_xsize16 : xsize_q;
      ysize_cur    = (state_q == StIdle) ? i_ysize16 : ysize_q;
      last_col     = (32'(bx_q) + 32'd1) == beats_per_row(32'(xsize_cur));
      last_row     = (32'(row_q) + 32'd1) == (32'd16 * 32'(ysize_cur));
      last_beat    = last_col && last_row;
      first_beat   = (bx_q == '0) && (row_q == '0);
   end

   mpeg2_pix_acc #(
      .IN_PIX (IN_PIX)
   ) u_acc (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (acc_clr),
      .en    (accept),
      .y     (i_Y),
      .u     (i_U),
      .v     (i_V),
      .done  (grp_done),
      .grp_y (grp_y),
      .grp_u (grp_u),
      .grp_v (grp_v)
   );

   // Control FSM, geometry counters and registered outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q         <= StIdle;
         stop_flag_q     <= 1'b0;
         xsize_q         <= '0;
         ysize_q         <= '0;
         bx_q            <= '0;
         row_q           <= '0;
         o_en            <= 1'b0;
         o_Y             <= '0;
         o_U             <= '0;
         o_V             <= '0;
         o_frame_start   <= 1'b0;
         o_frame_end     <= 1'b0;
         o_sequence_stop <= 1'b0;
         o_cfg_err       <= 1'b0;
      end else begin
         o_en            <= 1'b0;
         o_frame_start   <= 1'b0;
         o_frame_end     <= 1'b0;
         o_sequence_stop <= 1'b0;
         if (i_stop_req && state_q != StStopped) begin
            stop_flag_q <= 1'b1;
         end
         if (grp_done) begin
            o_en          <= 1'b1;
            o_Y           <= grp_y;
            o_U           <= (i_chroma_mode == CHROMA_444) ? grp_u : dup_even(grp_u);
            o_V           <= (i_chroma_mode == CHROMA_444) ? grp_v : dup_even(grp_v);
            o_frame_start <= first_beat;
            o_frame_end   <= last_beat;
            if (last_col) begin
               bx_q  <= '0;
               row_q <= last_row ? '0 : row_q + 1'b1;
            end else begin
               bx_q <= bx_q + 1'b1;
            end
         end
         unique case (state_q)
            StIdle: begin
               if (stop_flag_q) begin
                  o_sequence_stop <= 1'b1;
                  stop_flag_q     <= 1'b0;
                  state_q         <= StStopped;
               end else if (i_en) begin
                  xsize_q   <= i_xsize16;
                  ysize_q   <= i_ysize16;
                  o_cfg_err <= size_zero_in;
                  if (!size_zero_in) state_q <= StActive;
               end
            end
            StActive: begin
               if (grp_done && last_beat) state_q <= StIdle;
            end
            StStopped: begin
               if (!i_sequence_busy && !i_stop_req) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef MPEG2_PACKER_STATS_EN
   logic drop;

   // A beat is dropped while stopped or when the size about to be latched is zero
   always_comb begin
      drop = i_en && (state_q == StStopped ||
                      (state_q == StIdle && !stop_flag_q && size_zero_in));
   end

   // Saturating frame and drop counters
   always_ff @(posedge clk) begin
      if (!rstn) begin
         o_frame_count <= '0;
         o_drop_count  <= '0;
      end else begin
         if (grp_done && last_beat && o_frame_count != 16'hFFFF) begin
            o_frame_count <= o_frame_count + 16'd1;
         end
         if (drop && o_drop_count != 16'hFFFF) begin
            o_drop_count <= o_drop_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mpeg2_pixel_packer.sv
// Self-checking bench: a 4-pixel instance checked beat-by-beat against a queue
// model built from frame arithmetic, plus a 1-pixel instance for packing/reset.
module tb_mpeg2_pixel_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   int unsigned cyc = 0;
   int unsigned errors = 0;
   int unsigned checks = 0;

   // 4-pixel instance
   logic        en4, mode4, stop4, busy4;
   logic [6:0]  xs4, ys4;
   logic [31:0] y4, u4, v4;
   logic        o_en4, o_fs4, o_fe4, o_stop4, o_cfg4;
   logic [31:0] o_y4, o_u4, o_v4;

   // 1-pixel instance
   logic        en1;
   logic [7:0]  y1, u1, v1;
   logic [6:0]  xs1 = 7'd1, ys1 = 7'd1;
   logic        mode1 = 1'b0, stop1 = 1'b0, busy1 = 1'b0;
   logic        o_en1, o_fs1, o_fe1, o_stop1, o_cfg1;
   logic [31:0] o_y1, o_u1, o_v1;

`ifdef MPEG2_PACKER_STATS_EN
   logic [15:0] fc4, dc4, fc1, dc1;
`endif

   mpeg2_pixel_packer #(.IN_PIX(4), .XL(6), .YL(6)) dut4 (
      .clk (clk), .rstn (rstn), .i_xsize16 (xs4), .i_ysize16 (ys4),
      .i_chroma_mode (mode4), .i_en (en4), .i_Y (y4), .i_U (u4), .i_V (v4),
      .i_stop_req (stop4), .i_sequence_busy (busy4), .o_en (o_en4),
      .o_Y (o_y4), .o_U (o_u4), .o_V (o_v4), .o_frame_start (o_fs4),
      .o_frame_end (o_fe4), .o_sequence_stop (o_stop4),
`ifdef MPEG2_PACKER_STATS_EN
      .o_frame_count (fc4), .o_drop_count (dc4),
`endif
      .o_cfg_err (o_cfg4)
   );

   mpeg2_pixel_packer #(.IN_PIX(1), .XL(6), .YL(6)) dut1 (
      .clk (clk), .rstn (rstn), .i_xsize16 (xs1), .i_ysize16 (ys1),
      .i_chroma_mode (mode1), .i_en (en1), .i_Y (y1), .i_U (u1), .i_V (v1),
      .i_stop_req (stop1), .i_sequence_busy (busy1), .o_en (o_en1),
      .o_Y (o_y1), .o_U (o_u1), .o_V (o_v1), .o_frame_start (o_fs1),
      .o_frame_end (o_fe1), .o_sequence_stop (o_stop1),
`ifdef MPEG2_PACKER_STATS_EN
      .o_frame_count (fc1), .o_drop_count (dc1),
`endif
      .o_cfg_err (o_cfg1)
   );

   typedef struct {
      logic [31:0] y, u, v;
      logic        fs, fe;
      int unsigned cyc;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned m_idx = 0;
   int unsigned m_total = 64;
   int unsigned last_cyc = 0;
   int unsigned stop_cnt = 0;
   int unsigned stop_cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference chroma rule: every odd lane copies the lane to its left
   function automatic logic [31:0] ref_dup(input logic [31:0] c);
      logic [7:0] px [4];
      logic [31:0] r;
      for (int k = 0; k < 4; k++) px[k] = c[8*k +: 8];
      for (int k = 1; k < 4; k += 2) px[k] = px[k-1];
      for (int k = 0; k < 4; k++) r[8*k +: 8] = px[k];
      return r;
   endfunction

   // One beat into dut4; unless dropped, the model predicts its output
   task automatic drive4(input logic [31:0] y, input logic [31:0] u, input logic [31:0] v,
                         input logic mode, input bit drop);
      exp_t e;
      @(posedge clk); #1;
      en4 = 1'b1; y4 = y; u4 = u; v4 = v; mode4 = mode;
      if (!drop) begin
         e.y   = y;
         e.u   = mode ? ref_dup(u) : u;
         e.v   = mode ? ref_dup(v) : v;
         e.fs  = (m_idx == 0);
         e.fe  = (m_idx == m_total - 1);
         e.cyc = cyc + 1;
         exp_q.push_back(e);
         m_idx = (m_idx == m_total - 1) ? 0 : m_idx + 1;
      end
      last_cyc = cyc;
   endtask

   task automatic idle4(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         en4 = 1'b0;
      end
   endtask

   task automatic drive1(input logic [7:0] y);
      @(posedge clk); #1;
      en1 = 1'b1; y1 = y; u1 = y; v1 = y;
   endtask

   task automatic rand_frame(input bit gaps);
      for (int n = 0; n < int'(m_total); n++) begin
         drive4($urandom(), $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'b0);
         if (gaps && $urandom_range(0, 3) == 0) idle4(1);
      end
   endtask

   task automatic mon_step();
      exp_t e;
      if (rstn === 1'b1 && o_en4 === 1'b1) begin
         check("o_en_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("latency_cyc", cyc, e.cyc);
            check("o_Y", o_y4, e.y);
            check("o_U", o_u4, e.u);
            check("o_V", o_v4, e.v);
            check("frame_start", 32'(o_fs4), 32'(e.fs));
            check("frame_end", 32'(o_fe4), 32'(e.fe));
         end
      end
      if (o_stop4 === 1'b1) begin
         stop_cnt = stop_cnt + 1;
         stop_cyc = cyc;
      end
   endtask

   always begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   always begin
      @(negedge clk);
      mon_step();
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: observed no finish, expected finish within budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] u;
      int unsigned stop_l;
      rstn = 1'b0;
      en4 = 0; mode4 = 0; stop4 = 0; busy4 = 0; xs4 = 7'd1; ys4 = 7'd1;
      y4 = '0; u4 = '0; v4 = '0;
      en1 = 0; y1 = '0; u1 = '0; v1 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_o_en", 32'(o_en4), 0);
      check("rst_o_Y", o_y4, 0);
      check("rst_flags", {28'd0, o_fs4, o_fe4, o_stop4, o_cfg4}, 0);
      check("rst_o_en1", 32'(o_en1), 0);
      rstn = 1'b1;

      // 1-pixel packing: 4 beats make one output beat one cycle after the 4th
      drive1(8'h0A); drive1(8'h0B); drive1(8'h0C); drive1(8'h0D);
      check("pack1_not_early", 32'(o_en1), 0);
      @(posedge clk); #1; en1 = 1'b0;
      check("pack1_en", 32'(o_en1), 1);
      check("pack1_Y", o_y1, 32'h0D0C0B0A);
      check("pack1_fs", 32'(o_fs1), 1);

      // Reset with two lanes filled discards the partial group and counters
      drive1(8'h20); drive1(8'h21);
      @(posedge clk); #1; en1 = 1'b0; rstn = 1'b0;
      @(posedge clk); #1;
      check("midrst_o_en1", 32'(o_en1), 0);
      check("midrst_o_Y1", o_y1, 0);
      rstn = 1'b1;
      drive1(8'h30); drive1(8'h31); drive1(8'h32); drive1(8'h33);
      @(posedge clk); #1; en1 = 1'b0;
      check("after_rst_en1", 32'(o_en1), 1);
      check("after_rst_Y1", o_y1, 32'h33323130);
      check("after_rst_fs1", 32'(o_fs1), 1);

      // Directed 64-beat frame with Y=n and chroma-mode spot checks
      m_total = 64;
      for (int n = 0; n < 64; n++) begin
         u = (n < 2) ? 32'h44332211 : $urandom();
         drive4(32'(n), u, $urandom(), (n == 0), 1'b0);
         if (n == 1) begin
            check("dup_U", o_u4, 32'h33331111);
            check("first_fs", 32'(o_fs4), 1);
         end
         if (n == 2) check("pass_U", o_u4, 32'h44332211);
      end
      idle4(1);
      check("last_fe", 32'(o_fe4), 1);
      check("last_Y", o_y4, 32'd63);
      idle4(3);

      // Random data and mode, with and without gaps, back to back
      rand_frame(1'b1);
      rand_frame(1'b0);
      idle4(3);

      // Stop requested mid-frame: frame completes, then stop pulse
      busy4 = 1'b1;
      for (int n = 0; n < 64; n++) begin
         stop4 = (n == 10);
         drive4($urandom(), $urandom(), $urandom(), 1'b0, 1'b0);
      end
      stop_l = last_cyc;
      idle4(4);
      check("stop_count", stop_cnt, 1);
      check("stop_after_fe", stop_cyc, stop_l + 2);
      for (int n = 0; n < 6; n++) drive4($urandom(), $urandom(), $urandom(), 1'b0, 1'b1);
      idle4(14);
      busy4 = 1'b0;
      idle4(2);
      rand_frame(1'b1);
      idle4(3);
      check("no_extra_stop", stop_cnt, 1);

      // Zero width: error flag and dropped beats; then a 2-macroblock-wide frame
      xs4 = 7'd0;
      for (int n = 0; n < 3; n++) drive4($urandom(), $urandom(), $urandom(), 1'b0, 1'b1);
      idle4(2);
      check("cfg_err_set", 32'(o_cfg4), 1);
      xs4 = 7'd2;
      m_total = 128;
      drive4($urandom(), $urandom(), $urandom(), 1'b0, 1'b0);
      drive4($urandom(), $urandom(), $urandom(), 1'b0, 1'b0);
      check("cfg_err_clear", 32'(o_cfg4), 0);
      for (int n = 2; n < 128; n++) drive4($urandom(), $urandom(), $urandom(), 1'b1, 1'b0);
      idle4(4);

      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mpeg2_pixel_packer.md
Name: mpeg2_pixel_packer

Overview:
Parametrised pixel front-end placed in front of mpeg2encoder. It accepts 1, 2 or 4 YUV 4:4:4 pixels per beat and packs them into the encoder's 4-pixel beat. It applies a run-time chroma mode (full 4:4:4 or even-sample duplication) and tracks x/y position against the macroblock frame size. Sequence-stop requests are deferred to the next frame boundary, so the encoder never sees a truncated frame.

Parameters:
- IN_PIX, 4, pixels per input beat; legal values 1, 2, 4.
- XL, 6, log2 of max horizontal size in 16-pixel macroblocks (6 -> 1024 pixels).
- YL, 6, log2 of max vertical size in 16-pixel macroblocks.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- i_xsize16  in  XL+1  frame width in macroblocks.
- i_ysize16  in  YL+1  frame height in macroblocks.
- i_chroma_mode  in  1  0 = 4:4:4 passthrough; 1 = duplicate even chroma (U1=U0, U3=U2, same for V).
- i_en  in  1  input beat valid.
- i_Y, i_U, i_V  in  8*IN_PIX each  pixels; pixel k at bits [8k+7:8k], k=0 leftmost.
- i_stop_req  in  1  level request to end the sequence.
- i_sequence_busy  in  1  from encoder o_sequence_busy.
- o_en  out  1  packed beat valid.
- o_Y, o_U, o_V  out  32 each  4 packed pixels, same lane order.
- o_frame_start  out  1  with o_en on first beat of a frame.
- o_frame_end  out  1  with o_en on last beat of a frame.
- o_sequence_stop  out  1  one-cycle stop pulse to encoder.
- o_cfg_err  out  1  latched size is zero.

Behaviour:
- Reset: all outputs 0; accumulator, counters and the stop flag cleared; FSM = IDLE.
- Accumulation: 4/IN_PIX input beats form one output beat. Lane index increments per accepted i_en. When the group completes, o_en and data register out on the next cycle, giving a fixed 1-cycle latency. IN_PIX=4 is therefore a registered passthrough.
- Chroma mode is applied at the output register. i_chroma_mode is sampled per output beat.
- Geometry: i_xsize16 and i_ysize16 are latched on the first accepted beat in IDLE.
  - Output-beat column bx counts 0..4*xsize16-1.
  - Row y counts 0..16*ysize16-1.
  - On the last beat of a row, bx wraps to 0 and y increments.
  - The last beat of the frame asserts o_frame_end; counters return to 0 and the FSM goes to IDLE.
- Zero size: if the latched xsize16 or ysize16 is 0, o_cfg_err = 1 and beats are dropped (o_en stays 0) until IDLE re-latches a nonzero size.
- FSM states:
  - IDLE: if the stop flag is set, pulse o_sequence_stop and go to STOPPED. Otherwise, i_en latches the config and goes to ACTIVE; the first output beat carries o_frame_start.
  - ACTIVE: packs beats. At o_frame_end, go to IDLE. A pending stop is handled by IDLE on the following cycle, so o_sequence_stop fires 1 cycle after o_frame_end.
  - STOPPED: i_en is ignored and the accumulator is cleared. Exit to IDLE when i_sequence_busy = 0 and i_stop_req = 0. Remain in STOPPED while busy is high, even if i_stop_req falls.
- Stop flag: sticky, set on any cycle with i_stop_req = 1 in IDLE or ACTIVE. Cleared when o_sequence_stop is emitted.
- Simultaneous events: stop request on the frame's last input beat is accepted; the frame completes, then the stop pulse follows.
- Reset mid-frame: partial group and counters are discarded; no o_frame_end is emitted.
- i_en in STOPPED: dropped without error.

Optional Feature:
- Macro: MPEG2_PACKER_STATS_EN.
- Defined: adds o_frame_count (16 bits) and o_drop_count (16 bits).
  - o_frame_count increments on each o_frame_end.
  - o_drop_count increments on each i_en dropped in STOPPED or under o_cfg_err.
  - Both saturate, and both clear on reset.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Shared package mpeg2_pkg holds:
  - state enum (IDLE, ACTIVE, STOPPED);
  - chroma mode constants CHROMA_444 = 0, CHROMA_DUP = 1;
  - function beats_per_row(xsize16) = 4*xsize16.
- One sub-module, mpeg2_pix_acc: the IN_PIX-to-4 lane accumulator with clear input and group-complete strobe.

Test Plan:
- IN_PIX=4, xsize16=1, ysize16=1, 64 beats of Y=n → 64 o_en beats, 1 cycle latency; o_frame_start on beat 0, o_frame_end on beat 63.
- IN_PIX=1, 4 beats Y=10,11,12,13 → single o_Y=0x0D0C0B0A one cycle after the 4th beat.
- chroma_mode=1, i_U=0x44332211 → o_U=0x33331111; mode 0 → 0x44332211.
- Stop asserted at beat 10 of a 64-beat frame → all 64 beats out, o_sequence_stop 1 cycle after o_frame_end. Input during STOPPED is dropped. Holding busy=1 for 20 cycles then 0 with stop low → IDLE.
- xsize16=0 → o_cfg_err=1, no o_en. Next frame with xsize16=2 → o_cfg_err=0, 128 beats per 16 rows.
- rstn low mid-row with 2 of 4 lanes filled → no output; the next frame starts with o_frame_start at y=0.
